// File: rtl/cam_entry_manager.sv
// Single-request CAM entry manager: lookup / insert / delete against a block-RAM CAM.
// Optional CAM_MGR_STATS_EN adds an occupancy output counting used entries.
module cam_entry_manager #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 5,
  parameter int LOOKUP_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_key,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [1:0]            resp_status,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic [DATA_WIDTH-1:0] cam_compare_data,
  input  logic                  cam_match,
  input  logic [ADDR_WIDTH-1:0] cam_match_addr,
  output logic [ADDR_WIDTH-1:0] cam_write_addr,
  output logic [DATA_WIDTH-1:0] cam_write_data,
  output logic                  cam_write_delete,
  output logic                  cam_write_enable,
  input  logic                  cam_write_busy
`ifdef CAM_MGR_STATS_EN
  ,
  output logic [ADDR_WIDTH:0]   occupancy
`endif
);

  // state    | meaning
  // IDLE     | ready for a request when the CAM write engine is idle
  // LOOKUP   | compare key driven, waiting out the CAM lookup latency
  // DECIDE   | classify hit/miss against the op, pick a slot
  // WR_ISSUE | waiting for the CAM to be idle, then pulse the write strobe
  // WR_WAIT  | waiting for the CAM write to complete, then update the bitmap
  // RESP     | response held until consumed

  localparam int ENTRIES = 1 << ADDR_WIDTH;

  localparam logic [1:0] ST_OK        = 2'd0;
  localparam logic [1:0] ST_EXISTS    = 2'd1;
  localparam logic [1:0] ST_FULL      = 2'd2;
  localparam logic [1:0] ST_NOT_FOUND = 2'd3;

  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_DECIDE,
    S_WR_ISSUE,
    S_WR_WAIT,
    S_RESP
  } state_t;

  state_t state, state_next;

  logic [2:0]            lat_cnt;
  logic [1:0]            op_q;
  logic [DATA_WIDTH-1:0] key_q;
  logic                  hit_q;
  logic [ADDR_WIDTH-1:0] hit_addr_q;
  logic [ENTRIES-1:0]    used_map;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic                  wr_del_q;
  logic                  wait_first_q;
  logic [1:0]            resp_status_q;
  logic [ADDR_WIDTH-1:0] resp_addr_q;

  logic                  accept;
  logic                  is_insert;
  logic                  is_delete;
  logic                  map_full;
  logic [ADDR_WIDTH-1:0] free_idx;
  logic                  need_write;
  logic                  write_done;

  assign accept     = req_valid && req_ready;
  assign is_insert  = (op_q == OP_INSERT);
  assign is_delete  = (op_q == OP_DELETE);
  assign map_full   = &used_map;
  assign need_write = (is_insert && !hit_q && !map_full) || (is_delete && hit_q);
  // CAM busy is registered, so it only reflects our strobe from the second WR_WAIT cycle on.
  assign write_done = (state == S_WR_WAIT) && !wait_first_q && !cam_write_busy;

  // Lowest-index free slot; scanning downward lets the lowest clear bit win.
  always_comb begin
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!used_map[i]) free_idx = ADDR_WIDTH'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (accept) state_next = S_LOOKUP;
      S_LOOKUP:   if (lat_cnt == 3'd0) state_next = S_DECIDE;
      S_DECIDE:   state_next = need_write ? S_WR_ISSUE : S_RESP;
      S_WR_ISSUE: if (!cam_write_busy) state_next = S_WR_WAIT;
      S_WR_WAIT:  if (write_done) state_next = S_RESP;
      S_RESP:     if (resp_ready) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready        = (state == S_IDLE) && !cam_write_busy;
    resp_valid       = (state == S_RESP);
    cam_write_enable = (state == S_WR_ISSUE) && !cam_write_busy;
    resp_status      = resp_status_q;
    resp_addr        = resp_addr_q;
    cam_compare_data = key_q;
    cam_write_data   = key_q;
    cam_write_addr   = wr_addr_q;
    cam_write_delete = wr_del_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt       <= '0;
      op_q          <= '0;
      key_q         <= '0;
      hit_q         <= 1'b0;
      hit_addr_q    <= '0;
      used_map      <= '0;
      wr_addr_q     <= '0;
      wr_del_q      <= 1'b0;
      wait_first_q  <= 1'b0;
      resp_status_q <= ST_OK;
      resp_addr_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q    <= req_op;
            key_q   <= req_key;
            lat_cnt <= 3'(LOOKUP_LATENCY);
          end
        end
        S_LOOKUP: begin
          if (lat_cnt == 3'd0) begin
            hit_q      <= cam_match;
            hit_addr_q <= cam_match_addr;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        S_DECIDE: begin
          wr_del_q <= is_delete;
          if (is_insert) begin
            if (hit_q) begin
              resp_status_q <= ST_EXISTS;
              resp_addr_q   <= hit_addr_q;
            end else if (map_full) begin
              resp_status_q <= ST_FULL;
              resp_addr_q   <= '0;
            end else begin
              wr_addr_q <= free_idx;
            end
          end else if (is_delete) begin
            if (hit_q) begin
              wr_addr_q <= hit_addr_q;
            end else begin
              resp_status_q <= ST_NOT_FOUND;
              resp_addr_q   <= '0;
            end
          end else begin
            resp_status_q <= hit_q ? ST_OK : ST_NOT_FOUND;
            resp_addr_q   <= hit_q ? hit_addr_q : '0;
          end
        end
        S_WR_ISSUE: begin
          if (!cam_write_busy) wait_first_q <= 1'b1;
        end
        S_WR_WAIT: begin
          wait_first_q <= 1'b0;
          if (write_done) begin
            used_map[wr_addr_q] <= !wr_del_q;
            resp_status_q       <= ST_OK;
            resp_addr_q         <= wr_addr_q;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CAM_MGR_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy <= '0;
    end else if (write_done) begin
      if (wr_del_q) occupancy <= occupancy - {{ADDR_WIDTH{1'b0}}, 1'b1};
      else          occupancy <= occupancy + {{ADDR_WIDTH{1'b0}}, 1'b1};
    end
  end
`endif

endmodule

// File: tb/tb_cam_entry_manager.sv
// Directed bench for cam_entry_manager with a small behavioural CAM (4 entries, 1-cycle lookup).
module tb_cam_entry_manager;
  localparam int DW = 64;
  localparam int AW = 2;
  localparam int LAT = 1;
  localparam int N = 4;
  localparam int INIT = 6;
  localparam logic [1:0] OK = 2'd0, EXISTS = 2'd1, FULL = 2'd2, NOT_FOUND = 2'd3;
  localparam logic [1:0] OP_LK = 2'b00, OP_INS = 2'b01, OP_DEL = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_ready;
  logic [1:0] req_op = '0;
  logic [DW-1:0] req_key = '0;
  logic resp_valid, resp_ready = 1'b1;
  logic [1:0] resp_status;
  logic [AW-1:0] resp_addr;
  logic [DW-1:0] cam_compare_data;
  logic cam_match;
  logic [AW-1:0] cam_match_addr;
  logic [AW-1:0] cam_write_addr;
  logic [DW-1:0] cam_write_data;
  logic cam_write_delete, cam_write_enable, cam_write_busy;
`ifdef CAM_MGR_STATS_EN
  logic [AW:0] occupancy;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cam_entry_manager #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOOKUP_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_key(req_key),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_status(resp_status), .resp_addr(resp_addr),
    .cam_compare_data(cam_compare_data), .cam_match(cam_match), .cam_match_addr(cam_match_addr),
    .cam_write_addr(cam_write_addr), .cam_write_data(cam_write_data),
    .cam_write_delete(cam_write_delete), .cam_write_enable(cam_write_enable),
    .cam_write_busy(cam_write_busy)
`ifdef CAM_MGR_STATS_EN
    , .occupancy(occupancy)
`endif
  );

  // Behavioural CAM: busy during init after reset, insert write 5 cycles, delete 3.
  logic [DW-1:0] cam_key [N];
  logic          cam_vld [N];
  int            busy_cnt;
  logic          m_hit;
  logic [AW-1:0] m_addr;
  int            wr_count;
  logic [AW-1:0] last_wr_addr;
  logic          last_wr_del;
  logic [DW-1:0] last_wr_data;

  assign cam_write_busy = (busy_cnt != 0);

  always_comb begin
    m_hit = 1'b0;
    m_addr = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cam_vld[i] && cam_key[i] == cam_compare_data) begin
        m_hit = 1'b1;
        m_addr = AW'(i);
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      busy_cnt <= INIT;
      for (int i = 0; i < N; i++) begin cam_vld[i] <= 1'b0; cam_key[i] <= '0; end
      cam_match <= 1'b0;
      cam_match_addr <= '0;
    end else begin
      cam_match <= m_hit;
      cam_match_addr <= m_addr;
      if (cam_write_enable) begin
        cam_vld[cam_write_addr] <= !cam_write_delete;
        cam_key[cam_write_addr] <= cam_write_data;
        busy_cnt <= cam_write_delete ? 3 : 5;
      end else if (busy_cnt != 0) begin
        busy_cnt <= busy_cnt - 1;
      end
    end
  end

  initial wr_count = 0;
  always @(posedge clk) begin
    if (cam_write_enable) begin
      wr_count <= wr_count + 1;
      last_wr_addr <= cam_write_addr;
      last_wr_del <= cam_write_delete;
      last_wr_data <= cam_write_data;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one request, waits for its response; handshakes only if resp_ready is high.
  task automatic send_req(input logic [1:0] op, input logic [DW-1:0] key,
                          output logic [1:0] st, output logic [AW-1:0] ad, output int lat);
    int n;
    st = 2'bxx; ad = 'x; lat = -1;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_key = key;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL accept_timeout key=%0h req_ready=%b exp 1", key, req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    if (lat >= 200) begin
      checks++; errors++;
      $display("FAIL resp_timeout key=%0h resp_valid=%b exp 1", key, resp_valid);
      return;
    end
    st = resp_status; ad = resp_addr;
    if (resp_ready) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b exp 0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid); end
    checks++; if ({resp_status, resp_addr} !== '0) begin errors++; $display("FAIL rst_resp got %0h/%0h exp 0/0", resp_status, resp_addr); end
    checks++; if ({cam_write_enable, cam_write_delete, cam_write_addr} !== '0) begin errors++; $display("FAIL rst_wr_ctl got %b/%b/%0h exp 0/0/0", cam_write_enable, cam_write_delete, cam_write_addr); end
    checks++; if ({cam_write_data, cam_compare_data} !== '0) begin errors++; $display("FAIL rst_data got %0h/%0h exp 0/0", cam_write_data, cam_compare_data); end
  endtask

  task automatic test_init_hold();
    int stall;
    int lat;
    bit held_ok;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b1; req_op = OP_LK; req_key = 64'h55;
    stall = 0; held_ok = 1'b1;
    while (cam_write_busy && stall < 50) begin
      if (req_ready !== 1'b0) held_ok = 1'b0;
      @(negedge clk); stall++;
    end
    checks++; if (!held_ok) begin errors++; $display("FAIL init_hold req_ready went high while busy, exp 0"); end
    checks++; if (stall != INIT) begin errors++; $display("FAIL init_stall got %0d cycles exp %0d", stall, INIT); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL init_ready got %b exp 1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
    checks++; if (lat != LAT + 2) begin errors++; $display("FAIL init_lookup_latency got %0d exp %0d", lat, LAT + 2); end
    checks++; if ({resp_status, resp_addr} !== {NOT_FOUND, 2'd0}) begin errors++; $display("FAIL init_lookup got %0d/%0d exp 3/0", resp_status, resp_addr); end
    @(posedge clk); #1;
  endtask

  task automatic test_insert_dup();
    logic [1:0] st; logic [AW-1:0] ad; int lat; int w0;
    w0 = wr_count;
    send_req(OP_INS, 64'h1234, st, ad, lat);
    checks++; if ({st, ad} !== {OK, 2'd0}) begin errors++; $display("FAIL ins_1234 got %0d/%0d exp 0/0", st, ad); end
    checks++; if (wr_count - w0 != 1) begin errors++; $display("FAIL ins_1234_strobes got %0d exp 1", wr_count - w0); end
    checks++; if ({last_wr_addr, last_wr_del, last_wr_data} !== {2'd0, 1'b0, 64'h1234}) begin errors++; $display("FAIL ins_1234_wr got a=%0d d=%b k=%0h exp 0/0/1234", last_wr_addr, last_wr_del, last_wr_data); end
    w0 = wr_count;
    send_req(OP_INS, 64'h1234, st, ad, lat);
    checks++; if ({st, ad} !== {EXISTS, 2'd0}) begin errors++; $display("FAIL ins_dup got %0d/%0d exp 1/0", st, ad); end
    checks++; if (wr_count != w0) begin errors++; $display("FAIL ins_dup_strobes got %0d exp 0", wr_count - w0); end
    send_req(OP_LK, 64'h1234, st, ad, lat);
    checks++; if ({st, ad} !== {OK, 2'd0} || lat != LAT + 2) begin errors++; $display("FAIL lookup_1234 got %0d/%0d lat %0d exp 0/0 lat %0d", st, ad, lat, LAT + 2); end
  endtask

  task automatic test_fill();
    logic [1:0] st; logic [AW-1:0] ad; int lat; int w0;
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      send_req(OP_INS, DW'(k), st, ad, lat);
      checks++; if ({st, ad} !== {OK, AW'(k - 1)}) begin errors++; $display("FAIL fill_key%0d got %0d/%0d exp 0/%0d", k, st, ad, k - 1); end
    end
    w0 = wr_count;
    send_req(OP_INS, 64'd5, st, ad, lat);
    checks++; if ({st, ad} !== {FULL, 2'd0}) begin errors++; $display("FAIL full_key5 got %0d/%0d exp 2/0", st, ad); end
    checks++; if (wr_count != w0) begin errors++; $display("FAIL full_strobes got %0d exp 0", wr_count - w0); end
`ifdef CAM_MGR_STATS_EN
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL occ_full got %0d exp 4", occupancy); end
`endif
  endtask

  task automatic test_delete_reuse();
    logic [1:0] st; logic [AW-1:0] ad; int lat; int w0;
    w0 = wr_count;
    send_req(OP_DEL, 64'd2, st, ad, lat);
    checks++; if ({st, ad} !== {OK, 2'd1}) begin errors++; $display("FAIL del_key2 got %0d/%0d exp 0/1", st, ad); end
    checks++; if (wr_count - w0 != 1 || {last_wr_addr, last_wr_del} !== {2'd1, 1'b1}) begin errors++; $display("FAIL del_key2_wr got n=%0d a=%0d d=%b exp 1/1/1", wr_count - w0, last_wr_addr, last_wr_del); end
`ifdef CAM_MGR_STATS_EN
    checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL occ_after_del got %0d exp 3", occupancy); end
`endif
    send_req(OP_INS, 64'd9, st, ad, lat);
    checks++; if ({st, ad} !== {OK, 2'd1}) begin errors++; $display("FAIL reuse_key9 got %0d/%0d exp 0/1", st, ad); end
    w0 = wr_count;
    send_req(OP_DEL, 64'd7, st, ad, lat);
    checks++; if ({st, ad} !== {NOT_FOUND, 2'd0} || wr_count != w0) begin errors++; $display("FAIL del_missing got %0d/%0d strobes %0d exp 3/0 strobes 0", st, ad, wr_count - w0); end
  endtask

  task automatic test_backpressure();
    logic [1:0] st; logic [AW-1:0] ad; int lat;
    bit stable;
    resp_ready = 1'b0;
    send_req(OP_LK, 64'd3, st, ad, lat);
    checks++; if ({st, ad} !== {OK, 2'd2}) begin errors++; $display("FAIL bp_lookup got %0d/%0d exp 0/2", st, ad); end
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b1 || resp_status !== OK || resp_addr !== 2'd2 || req_ready !== 1'b0) stable = 1'b0;
    end
    checks++; if (!stable) begin errors++; $display("FAIL bp_hold got v=%b s=%0d a=%0d rr=%b exp 1/0/2/0", resp_valid, resp_status, resp_addr, req_ready); end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release got v=%b rr=%b exp 0/1", resp_valid, req_ready); end
    send_req(2'b11, 64'd4, st, ad, lat);
    checks++; if ({st, ad} !== {OK, 2'd3}) begin errors++; $display("FAIL op11_lookup got %0d/%0d exp 0/3", st, ad); end
  endtask

  task automatic test_reset_wr_wait();
    logic [1:0] st; logic [AW-1:0] ad; int lat; int n;
    bit quiet;
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_DEL; req_key = 64'd4;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (cam_write_enable !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    checks++; if (n >= 50) begin errors++; $display("FAIL rstww_strobe got no strobe exp 1"); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if ({req_ready, resp_valid, cam_write_enable, cam_write_delete} !== 4'b0) begin errors++; $display("FAIL rstww_ctl got rr=%b v=%b we=%b del=%b exp 0000", req_ready, resp_valid, cam_write_enable, cam_write_delete); end
    checks++; if ({resp_status, resp_addr, cam_write_addr, cam_write_data, cam_compare_data} !== '0) begin errors++; $display("FAIL rstww_data got s=%0d a=%0d wa=%0d wd=%0h cd=%0h exp all 0", resp_status, resp_addr, cam_write_addr, cam_write_data, cam_compare_data); end
    quiet = 1'b1;
    repeat (12) begin @(posedge clk); #1; if (resp_valid !== 1'b0) quiet = 1'b0; end
    checks++; if (!quiet) begin errors++; $display("FAIL rstww_no_resp got resp_valid=1 exp 0"); end
    send_req(OP_INS, 64'h77, st, ad, lat);
    checks++; if ({st, ad} !== {OK, 2'd0}) begin errors++; $display("FAIL rstww_realloc got %0d/%0d exp 0/0", st, ad); end
`ifdef CAM_MGR_STATS_EN
    checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL occ_after_rst got %0d exp 1", occupancy); end
`endif
  endtask

  initial begin
    test_reset();
    test_init_hold();
    test_insert_dup();
    test_fill();
    test_delete_reuse();
    test_backpressure();
    test_reset_wr_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached exp completion");
    $fatal(1);
  end

endmodule
